event_packer_fifo: RTL and testbench

//  Downstream stage of the pixel arbiter. Captures each granted event (row x, col y, polarity),

---
 rtl/arbiter_pkg.sv | 43 ++++
 rtl/event_sync_fifo.sv | 76 +++++++
 rtl/event_packer_fifo.sv | 164 ++++++++++++++++
 tb/tb_event_packer_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared widths and types for the pixel arbiter and its event packer stage.
//   x_width / y_width : pixel address widths (row / column)
//   SIZE              : timestamp width
//   WIDTH             : packed event word width {x, y, ts, pol}
//   FIFO_DEPTH        : default depth of the event FIFO
//   CNT_W             : default width of the dropped-event counter
//   event_word_t      : packed layout of one event word, MSB first
// -----------------------------------------------------------------------------
package arbiter_pkg;

    localparam int x_width    = 3;
    localparam int y_width    = 3;
    localparam int SIZE       = 32;
    localparam int WIDTH      = x_width + y_width + SIZE + 1;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;

    // Field order fixes the word layout: x[38:36], y[35:33], ts[32:1], pol[0].
    typedef struct packed {
        logic [x_width-1:0] x;
        logic [y_width-1:0] y;
        logic [SIZE-1:0]    ts;
        logic               pol;
    } event_word_t;

    // Builds one event word from a granted pixel and its timestamp.
    function automatic event_word_t packEvent(
        input logic [x_width-1:0] x,
        input logic [y_width-1:0] y,
        input logic [SIZE-1:0]    ts,
        input logic               pol
    );
        event_word_t w;
        w.x   = x;
        w.y   = y;
        w.ts  = ts;
        w.pol = pol;
        return w;
    endfunction

endpackage

// File: rtl/event_sync_fifo.sv
// -----------------------------------------------------------------------------
// event_sync_fifo
// Single-clock show-ahead FIFO used to buffer packed event words.
//   clk_i    : clock
//   reset_i  : asynchronous active-low reset, empties the FIFO
//   push_i   : write wdata_i (accepted when not full, or when popping this cycle)
//   pop_i    : remove the head entry (ignored when empty)
//   wdata_i  : word to write
//   rdata_o  : current head entry (meaningful only while not empty)
//   full_o   : FIFO holds DEPTH entries
//   empty_o  : FIFO holds no entries
//   count_o  : occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module event_sync_fifo
    import arbiter_pkg::*;
#(
    parameter int DATA_W = WIDTH,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wrPtr_q;
    logic [AW:0]       wrPtr_d;
    logic [AW:0]       rdPtr_q;
    logic [AW:0]       rdPtr_d;
    logic              doPush;
    logic              doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate counter; occupancy is simply their difference.
    always_comb begin
        empty_o = (wrPtr_q == rdPtr_q);
        full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                  (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        count_o = wrPtr_q - rdPtr_q;
        rdata_o = mem_q[rdPtr_q[AW-1:0]];
        doPop   = pop_i && !empty_o;
        // A push into a full FIFO is legal only when the head leaves in the
        // same cycle; it then reuses the slot being vacated.
        doPush  = push_i && (!full_o || doPop);
        wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
    end

    // Storage array is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer registers; reset flushes whatever was queued.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

endmodule

// File: rtl/event_packer_fifo.sv
// -----------------------------------------------------------------------------
// event_packer_fifo
// Downstream stage of the pixel arbiter: stamps each granted event with a
// free-running timestamp, packs it into a WIDTH-bit word and buffers it in a
// FIFO drained over valid/ready. Events arriving while the FIFO is full are
// dropped, flagged (sticky overflow) and counted (saturating).
//   clk_i        : clock
//   reset_i      : asynchronous active-low reset
//   gnt_valid_i  : arbiter granted an event this cycle
//   x_add_i      : granted row index
//   y_add_i      : granted column index
//   polarity_i   : 1 = ON, 0 = OFF
//   ready_i      : consumer accepts data_out_o
//   data_out_o   : head word {x, y, ts, pol}, zero while empty
//   valid_o      : data_out_o holds a valid word
//   ts_wrap_o    : head entry is a timestamp wrap marker
//   fifo_count_o : FIFO occupancy
//   overflow_o   : at least one event dropped since reset
//   drop_cnt_o   : saturating count of dropped events
// Build option TS_WRAP_MARKER_EN: when defined, a marker word (all zero with
// ts_wrap_o = 1) is queued after every timestamp wrap. When undefined, no
// marker is generated and ts_wrap_o is tied low.
// -----------------------------------------------------------------------------
module event_packer_fifo
    import arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = arbiter_pkg::FIFO_DEPTH,
    parameter int CNT_W      = arbiter_pkg::CNT_W
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        gnt_valid_i,
    input  logic [x_width-1:0]          x_add_i,
    input  logic [y_width-1:0]          y_add_i,
    input  logic                        polarity_i,
    input  logic                        ready_i,
    output logic [WIDTH-1:0]            data_out_o,
    output logic                        valid_o,
    output logic                        ts_wrap_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        overflow_o,
    output logic [CNT_W-1:0]            drop_cnt_o
);

`ifdef TS_WRAP_MARKER_EN
    // Extra MSB tags a stored word as a wrap marker.
    localparam int STORE_W = WIDTH + 1;
`else
    localparam int STORE_W = WIDTH;
`endif

    logic [SIZE-1:0]    ts_q;
    logic [SIZE-1:0]    ts_d;
    logic               overflow_q;
    logic               overflow_d;
    logic [CNT_W-1:0]   dropCnt_q;
    logic [CNT_W-1:0]   dropCnt_d;

    event_word_t        eventWord;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPush;
    logic [STORE_W-1:0] fifoWdata;
    logic [STORE_W-1:0] fifoHead;
    logic               popThisCycle;
    logic               eventPush;
    logic               eventDrop;

`ifdef TS_WRAP_MARKER_EN
    logic               tsWrap;
    logic               markerPush;
    logic               markerPending_q;
    logic               markerPending_d;
`endif

    // Timestamp simply counts every cycle and wraps naturally at all-ones.
    assign ts_d = ts_q + SIZE'(1);

    // The word always carries the timestamp of the cycle the grant arrived in.
    assign eventWord = packEvent(x_add_i, y_add_i, ts_q, polarity_i);

    // Push/drop decision. A full FIFO still accepts an event when the head
    // is leaving in the same cycle, so nothing is dropped in that case.
    always_comb begin
        popThisCycle = !fifoEmpty && ready_i;
        eventPush    = gnt_valid_i && (!fifoFull || popThisCycle);
        eventDrop    = gnt_valid_i && fifoFull && !popThisCycle;
        overflow_d   = overflow_q || eventDrop;
        dropCnt_d    = dropCnt_q;
        if (eventDrop && (dropCnt_q != {CNT_W{1'b1}})) begin
            dropCnt_d = dropCnt_q + CNT_W'(1);
        end
    end

`ifdef TS_WRAP_MARKER_EN
    // Markers only use idle, non-full cycles so they never displace an event
    // and can never be dropped; a pending marker simply waits for a slot.
    always_comb begin
        tsWrap          = (ts_q == {SIZE{1'b1}});
        markerPush      = markerPending_q && !eventPush && !fifoFull;
        markerPending_d = (markerPending_q && !markerPush) || tsWrap;
        fifoPush        = eventPush || markerPush;
        fifoWdata       = eventPush ? {1'b0, eventWord} : {1'b1, {WIDTH{1'b0}}};
    end

    // Wrap marker pending flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            markerPending_q <= 1'b0;
        end else begin
            markerPending_q <= markerPending_d;
        end
    end
`else
    // Without markers the FIFO carries plain event words.
    always_comb begin
        fifoPush  = eventPush;
        fifoWdata = eventWord;
    end
`endif

    // Timestamp, sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    event_sync_fifo #(
        .DATA_W (STORE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifoPush),
        .pop_i   (popThisCycle),
        .wdata_i (fifoWdata),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifo_count_o)
    );

    // Outputs are masked while empty so stale storage never appears on the
    // bus and everything reads zero straight out of reset.
    always_comb begin
        valid_o    = !fifoEmpty;
        data_out_o = fifoEmpty ? '0 : fifoHead[WIDTH-1:0];
        overflow_o = overflow_q;
        drop_cnt_o = dropCnt_q;
`ifdef TS_WRAP_MARKER_EN
        ts_wrap_o  = !fifoEmpty && fifoHead[WIDTH];
`else
        ts_wrap_o  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_event_packer_fifo.sv
// -----------------------------------------------------------------------------
// tb_event_packer_fifo
// Directed sequence with randomized pixel data for event_packer_fifo, checked
// every cycle against a queue-based reference model. Honours TS_WRAP_MARKER_EN.
// -----------------------------------------------------------------------------
module tb_event_packer_fifo;
    import arbiter_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = 16;
`ifdef TS_WRAP_MARKER_EN
    localparam bit MARKER_EN = 1'b1;
`else
    localparam bit MARKER_EN = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic                     gnt_valid_i;
    logic [x_width-1:0]       x_add_i;
    logic [y_width-1:0]       y_add_i;
    logic                     polarity_i;
    logic                     ready_i;
    logic [WIDTH-1:0]         data_out_o;
    logic                     valid_o;
    logic                     ts_wrap_o;
    logic [$clog2(DEPTH):0]   fifo_count_o;
    logic                     overflow_o;
    logic [CW-1:0]            drop_cnt_o;

    // Reference model state: queue of {marker, word}, timestamp, drop status.
    logic [WIDTH:0]  mq[$];
    logic [SIZE-1:0] tsModel;
    logic            overflowModel;
    int              dropModel;
    logic            pendingModel;

    int vectors    = 0;
    int miscompares = 0;

    event_packer_fifo #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .gnt_valid_i  (gnt_valid_i),
        .x_add_i      (x_add_i),
        .y_add_i      (y_add_i),
        .polarity_i   (polarity_i),
        .ready_i      (ready_i),
        .data_out_o   (data_out_o),
        .valid_o      (valid_o),
        .ts_wrap_o    (ts_wrap_o),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mq.delete();
        tsModel       = '0;
        overflowModel = 1'b0;
        dropModel     = 0;
        pendingModel  = 1'b0;
    endtask

    // Compares every output with the model; called on the falling edge.
    task automatic checkAll();
        logic [WIDTH:0] head;
        checkOutput("valid", valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            head = mq[0];
            checkOutput("data", data_out_o, head[WIDTH-1:0]);
            checkOutput("ts_wrap", ts_wrap_o, head[WIDTH]);
        end else begin
            checkOutput("data_empty", data_out_o, 0);
            checkOutput("ts_wrap_empty", ts_wrap_o, 0);
        end
        checkOutput("count", fifo_count_o, mq.size());
        checkOutput("overflow", overflow_o, overflowModel);
        checkOutput("drop_cnt", drop_cnt_o, dropModel);
    endtask

    // Drives one cycle of inputs from the falling edge, advances the model by
    // the spec rules, waits through the rising edge and checks the result.
    task automatic applyStimulus(input logic gnt, input logic [x_width-1:0] x,
                                 input logic [y_width-1:0] y, input logic pol,
                                 input logic rdy);
        bit pop, full, evPush, mkPush;
        gnt_valid_i = gnt;
        x_add_i     = x;
        y_add_i     = y;
        polarity_i  = pol;
        ready_i     = rdy;
        pop    = (mq.size() != 0) && rdy;
        full   = (mq.size() == DEPTH);
        evPush = gnt && (!full || pop);
        mkPush = MARKER_EN && pendingModel && !evPush && !full;
        if (pop) void'(mq.pop_front());
        if (evPush) mq.push_back({1'b0, x, y, tsModel, pol});
        else if (mkPush) mq.push_back({1'b1, {WIDTH{1'b0}}});
        if (gnt && !evPush) begin
            overflowModel = 1'b1;
            if (dropModel < (1 << CW) - 1) dropModel++;
        end
        pendingModel = (pendingModel && !mkPush) || (tsModel == 32'hFFFF_FFFF);
        tsModel = tsModel + 32'd1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkAll();
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, '0, '0, 1'b0, rdy);
    endtask

    task automatic randomGrant(input logic rdy);
        applyStimulus(1'b1, x_width'($urandom), y_width'($urandom), 1'($urandom), rdy);
    endtask

    initial begin
        reset_i     = 1'b0;
        gnt_valid_i = 1'b0;
        x_add_i     = '0;
        y_add_i     = '0;
        polarity_i  = 1'b0;
        ready_i     = 1'b0;
        resetModel();
        repeat (2) @(negedge clk_i);
        $display("[TB] reset state");
        checkAll();
        reset_i = 1'b1;

        $display("[TB] single grant at ts=10");
        repeat (10) idle(1'b1);
        applyStimulus(1'b1, 3'd5, 3'd2, 1'b1, 1'b1);
        checkOutput("t1_word", data_out_o, {3'd5, 3'd2, 32'd10, 1'b1});
        idle(1'b1);
        checkOutput("t1_empty", valid_o, 1'b0);

        $display("[TB] 20 grants with consumer stalled");
        repeat (20) randomGrant(1'b0);
        checkOutput("t2_count", fifo_count_o, 16);
        checkOutput("t2_overflow", overflow_o, 1'b1);
        checkOutput("t2_drops", drop_cnt_o, 4);
        repeat (17) idle(1'b1);

        $display("[TB] full FIFO with grant and pop together");
        repeat (16) randomGrant(1'b0);
        randomGrant(1'b1);
        checkOutput("t3_count", fifo_count_o, 16);
        checkOutput("t3_drops", drop_cnt_o, 4);
        repeat (17) idle(1'b1);

        $display("[TB] toggling ready during 8-event stream");
        for (int i = 0; i < 20; i++) begin
            if (i < 8) randomGrant(1'(i));
            else idle(1'(i));
        end
        repeat (4) idle(1'b1);
        checkOutput("t4_drained", valid_o, 1'b0);

        $display("[TB] timestamp wrap");
        force dut.ts_d = 32'hFFFF_FFFE;
        idle(1'b0);
        release dut.ts_d;
        tsModel = 32'hFFFF_FFFE;
        idle(1'b0);
        randomGrant(1'b0);
        randomGrant(1'b0);
        idle(1'b0);
        checkOutput("t5_count", fifo_count_o, MARKER_EN ? 3 : 2);
        repeat (4) idle(1'b1);

        $display("[TB] reset with 6 entries queued");
        repeat (6) randomGrant(1'b0);
        reset_i = 1'b0;
        #1;
        checkOutput("t6_valid", valid_o, 1'b0);
        checkOutput("t6_count", fifo_count_o, 0);
        checkOutput("t6_drops", drop_cnt_o, 0);
        checkOutput("t6_overflow", overflow_o, 1'b0);
        checkOutput("t6_data", data_out_o, 0);
        resetModel();
        @(negedge clk_i);
        reset_i = 1'b1;
        applyStimulus(1'b1, 3'd3, 3'd6, 1'b0, 1'b0);
        checkOutput("t6_ts_restart", data_out_o, {3'd3, 3'd6, 32'd0, 1'b0});
        repeat (3) randomGrant(1'b1);
        repeat (4) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
